// File: rtl/rsa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_ctrl_pkg
//  Description : Shared types and codes for the rsa_unit job arbiter.
//                Holds the arbiter state encoding, the completion status
//                codes and the requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_ctrl_pkg;

    // Arbiter state encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } rsa_state_t;

    // Completion status returned alongside done_*
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    // Requester identifiers; also used as bit index into the pending vector
    localparam logic REQ_GPIO = 1'b0;
    localparam logic REQ_SPI  = 1'b1;

endpackage : rsa_ctrl_pkg
`default_nettype wire

// File: rtl/rsa_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_watchdog
//  Description : Clearable, enabled up-counter with a programmable terminal
//                value. Shared by the setup phase and the run-time watchdog.
//  Ports       : clk    - system clock
//                rst    - synchronous active-high reset
//                i_clr  - return count to zero (wins over i_en)
//                i_en   - advance count by one
//                i_term - terminal value compared against the count
//                o_tc   - count currently equals i_term
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_watchdog #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == i_term);

endmodule : rsa_watchdog
`default_nettype wire

// File: rtl/rsa_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_job_arbiter
//  Description : Shares one rsa_unit between the GPIO and SPI requesters.
//                Latches start pulses, grants round-robin, sequences the
//                enable / reset-release / run phases, guards RUN with a
//                timeout watchdog and returns a done pulse plus status.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                ena                      - global enable (freezes FSM)
//                req_gpio / req_spi       - start pulses
//                abort_gpio / abort_spi   - abort pulses
//                eoc_rsa_unit             - end of conversion from rsa_unit
//                en_rsa, rst_rsa          - rsa_unit enable / active-low reset
//                grant_gpio / grant_spi   - current owner indication
//                done_gpio / done_spi     - job-finished pulses
//                status                   - 00 OK, 01 TIMEOUT, 10 ABORT
//                busy                     - arbiter not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_job_arbiter
    import rsa_ctrl_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_gpio,
    input  logic       req_spi,
    input  logic       abort_gpio,
    input  logic       abort_spi,
    input  logic       eoc_rsa_unit,
    output logic       en_rsa,
    output logic       rst_rsa,
    output logic       grant_gpio,
    output logic       grant_spi,
    output logic       done_gpio,
    output logic       done_spi,
    output logic [1:0] status,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rsa_state_t r_state, w_state_nxt;
    logic [1:0] r_pend, w_pend_nxt;
    logic       r_owner;        // requester currently holding the unit
    logic       r_last;         // requester served by the most recent grant
    logic [1:0] r_status;       // outcome of the RUN phase (OK / TIMEOUT)

    logic [1:0] w_req, w_abort;
    logic       w_pick, w_grant_fire, w_abort_owner;
    logic       w_tc, w_cnt_clr, w_cnt_en;
    logic [CNT_W-1:0] w_cnt_term;
    logic       w_owns;

    assign w_req         = {req_spi, req_gpio};
    assign w_abort       = {abort_spi, abort_gpio};
    assign w_abort_owner = w_abort[r_owner];

    // Both pending: serve the one not served last; otherwise the only one pending.
    assign w_pick       = (&r_pend) ? ~r_last : r_pend[REQ_SPI];
    assign w_grant_fire = ena && (r_state == IDLE) && (|r_pend);

    // Pending capture is independent of ena. Abort beats a same-cycle
    // request; a fresh request re-queues even the requester being granted.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < 2; i++) begin
            if (w_abort[i]) begin
                w_pend_nxt[i] = 1'b0;
            end else if (w_req[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_grant_fire && (w_pick == 1'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            case (r_state)
                IDLE: begin
                    if (|r_pend) w_state_nxt = GRANT;
                end
                GRANT: begin
                    if (w_abort_owner)  w_state_nxt = ABORT;
                    else if (w_tc)      w_state_nxt = RUN;
                end
                RUN: begin
                    if (eoc_rsa_unit)       w_state_nxt = DONE;
                    else if (w_abort_owner) w_state_nxt = ABORT;
                    else if (w_tc)          w_state_nxt = DONE;
                end
                DONE:    w_state_nxt = IDLE;
                ABORT:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Counter restarts from zero on every state change, so the same
    // counter times the setup phase and then the run watchdog.
    assign w_cnt_clr  = (w_state_nxt != r_state);
    assign w_cnt_en   = ena && ((r_state == GRANT) || (r_state == RUN));
    assign w_cnt_term = (r_state == GRANT) ? C_SETUP_LAST : C_TIMEOUT_LAST;

    rsa_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .i_term (w_cnt_term),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pend   <= 2'b00;
            r_owner  <= REQ_GPIO;
            r_last   <= REQ_SPI;    // makes GPIO the first winner of a tie
            r_status <= ST_OK;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_grant_fire) begin
                r_owner <= w_pick;
                r_last  <= w_pick;
            end
            // Last write before leaving RUN is the one DONE reports.
            if (ena && (r_state == RUN)) begin
                r_status <= eoc_rsa_unit ? ST_OK : ST_TIMEOUT;
            end
        end
    end

    // Moore output decode
    assign w_owns     = (r_state == GRANT) || (r_state == RUN) || (r_state == DONE);
    assign en_rsa     = w_owns;
    assign rst_rsa    = (r_state == RUN) || (r_state == DONE);
    assign grant_gpio = w_owns && (r_owner == REQ_GPIO);
    assign grant_spi  = w_owns && (r_owner == REQ_SPI);
    assign done_gpio  = ((r_state == DONE) || (r_state == ABORT)) && (r_owner == REQ_GPIO);
    assign done_spi   = ((r_state == DONE) || (r_state == ABORT)) && (r_owner == REQ_SPI);
    assign status     = (r_state == ABORT) ? ST_ABORT :
                        (r_state == DONE)  ? r_status : ST_OK;
    assign busy       = (r_state != IDLE);

endmodule : rsa_job_arbiter
`default_nettype wire

// File: tb/tb_rsa_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_job_arbiter
//  Description : Self-checking bench for rsa_job_arbiter. A job-level model
//                (owner, age since grant, finishing kind) predicts every
//                output each cycle; directed scenarios add explicit checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_job_arbiter;

    localparam int SETUP   = 2;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst, ena, req_gpio, req_spi, abort_gpio, abort_spi, eoc_rsa_unit;
    logic en_rsa, rst_rsa, grant_gpio, grant_spi, done_gpio, done_spi, busy;
    logic [1:0] status;

    int errors = 0;
    int checks = 0;

    // Job-level model: fin 0 = no finishing cycle, 1 = done OK,
    // 2 = done TIMEOUT, 3 = aborted.
    bit m_pend [2];
    bit m_last, m_active, m_owner;
    int m_age, m_fin;

    rsa_job_arbiter #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .req_gpio     (req_gpio),
        .req_spi      (req_spi),
        .abort_gpio   (abort_gpio),
        .abort_spi    (abort_spi),
        .eoc_rsa_unit (eoc_rsa_unit),
        .en_rsa       (en_rsa),
        .rst_rsa      (rst_rsa),
        .grant_gpio   (grant_gpio),
        .grant_spi    (grant_spi),
        .done_gpio    (done_gpio),
        .done_spi     (done_spi),
        .status       (status),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        bit req [2], ab [2];
        bit granted;
        int pick;
        req[0] = req_gpio;   req[1] = req_spi;
        ab[0]  = abort_gpio; ab[1]  = abort_spi;
        granted = 0;
        pick    = 0;
        if (rst) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_last = 1; m_active = 0; m_owner = 0; m_age = 0; m_fin = 0;
            return;
        end
        if (ena) begin
            if (m_fin != 0) begin
                m_fin = 0;
            end else if (m_active) begin
                if (m_age < SETUP) begin
                    if (ab[m_owner]) begin m_fin = 3; m_active = 0; end
                    else m_age++;
                end else begin
                    if (eoc_rsa_unit)                     begin m_fin = 1; m_active = 0; end
                    else if (ab[m_owner])                 begin m_fin = 3; m_active = 0; end
                    else if (m_age - SETUP == TIMEOUT - 1) begin m_fin = 2; m_active = 0; end
                    else m_age++;
                end
            end else if (m_pend[0] || m_pend[1]) begin
                if (m_pend[0] && m_pend[1]) pick = m_last ? 0 : 1;
                else                        pick = m_pend[1] ? 1 : 0;
                granted  = 1;
                m_active = 1;
                m_owner  = pick[0];
                m_last   = pick[0];
                m_age    = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (ab[i])                     m_pend[i] = 0;
            else if (req[i])               m_pend[i] = 1;
            else if (granted && pick == i) m_pend[i] = 0;
        end
    endtask

    task automatic check_all();
        bit finish_run;
        finish_run = (m_fin == 1) || (m_fin == 2);
        chk("en_rsa",  en_rsa,  2'(m_active || finish_run));
        chk("rst_rsa", rst_rsa, 2'((m_active && m_age >= SETUP) || finish_run));
        chk("grant_gpio", grant_gpio, 2'((m_active || finish_run) && m_owner == 0));
        chk("grant_spi",  grant_spi,  2'((m_active || finish_run) && m_owner == 1));
        chk("done_gpio", done_gpio, 2'(m_fin != 0 && m_owner == 0));
        chk("done_spi",  done_spi,  2'(m_fin != 0 && m_owner == 1));
        chk("status", status, (m_fin == 2) ? 2'b01 : (m_fin == 3) ? 2'b10 : 2'b00);
        chk("busy", busy, 2'(m_active || m_fin != 0));
    endtask

    // One clock: compare current outputs, let DUT and model advance together.
    task automatic tick();
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse(input logic rg, input logic rs, input logic ag,
                         input logic as_, input logic ec);
        req_gpio = rg; req_spi = rs; abort_gpio = ag; abort_spi = as_; eoc_rsa_unit = ec;
        tick();
        req_gpio = 0; req_spi = 0; abort_gpio = 0; abort_spi = 0; eoc_rsa_unit = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Advance until the unit is released from reset (first RUN cycle).
    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (rst_rsa !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (rst_rsa !== 1'b1) begin
            errors++;
            $error("FAIL %s_timeout observed=%0d expected=1", tag, rst_rsa);
        end
    endtask

    initial begin
        rst = 1; ena = 1;
        req_gpio = 0; req_spi = 0; abort_gpio = 0; abort_spi = 0; eoc_rsa_unit = 0;
        repeat (2) @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 0;

        // Reset state
        chk("rst_en", en_rsa, 0);
        chk("rst_rstrsa", rst_rsa, 0);
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 0);

        // 1: request at N, eoc at N+10
        pulse(1, 0, 0, 0, 0);                      // cycle N
        chk("t1_en_n1", en_rsa, 0);                // N+1
        tick();
        chk("t1_en_n2", en_rsa, 1);                // N+2
        chk("t1_rstrsa_n2", rst_rsa, 0);
        repeat (2) tick();
        chk("t1_rstrsa_n4", rst_rsa, 1);           // N+4
        repeat (6) tick();                         // now N+10
        pulse(0, 0, 0, 0, 1);
        chk("t1_done_n11", done_gpio, 1);          // N+11
        chk("t1_status_n11", status, 0);
        tick();

        // 2: simultaneous requests twice -> GPIO, SPI, GPIO, SPI
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pulse(1, 1, 0, 0, 0);
            tick();
            chk("t2_first_gpio", grant_gpio, 1);
            chk("t2_first_nospi", grant_spi, 0);
            wait_run("t2a");
            tick();
            pulse(0, 0, 0, 0, 1);
            tick();
            tick();
            chk("t2_second_spi", grant_spi, 1);
            chk("t2_second_nogpio", grant_gpio, 0);
            wait_run("t2b");
            pulse(0, 0, 0, 0, 1);
            repeat (2) tick();
        end

        // 3: timeout
        pulse(1, 0, 0, 0, 0);
        wait_run("t3");
        repeat (TIMEOUT - 1) tick();
        chk("t3_still_run", done_gpio, 0);
        tick();
        chk("t3_done", done_gpio, 1);
        chk("t3_status", status, 1);
        tick();
        chk("t3_en_after", en_rsa, 0);

        // 4: owner abort in RUN
        pulse(0, 1, 0, 0, 0);
        wait_run("t4");
        repeat (3) tick();
        pulse(0, 0, 0, 1, 0);
        chk("t4_en", en_rsa, 0);
        chk("t4_rstrsa", rst_rsa, 0);
        chk("t4_done", done_spi, 1);
        chk("t4_status", status, 2);
        tick();

        // 5: eoc beats abort; non-owner abort is harmless
        pulse(1, 0, 0, 0, 0);
        wait_run("t5a");
        pulse(0, 0, 1, 0, 1);
        chk("t5_status_ok", status, 0);
        chk("t5_done", done_gpio, 1);
        tick();
        pulse(0, 1, 0, 0, 0);
        wait_run("t5b");
        pulse(0, 0, 1, 0, 0);
        tick();
        chk("t5_spi_still", grant_spi, 1);
        chk("t5_spi_run", rst_rsa, 1);
        pulse(0, 0, 0, 0, 1);
        chk("t5_spi_done", done_spi, 1);
        tick();

        // 6: freeze in RUN, then reset mid-RUN
        pulse(1, 0, 0, 0, 0);
        wait_run("t6");
        repeat (2) tick();
        ena = 0;
        repeat (5) tick();
        chk("t6_frozen_grant", grant_gpio, 1);
        ena = 1;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t6_rst_en", en_rsa, 0);
        chk("t6_rst_grant", grant_gpio, 0);
        chk("t6_rst_busy", busy, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(499) == 0);
            ena          = ($urandom_range(9) != 0);
            req_gpio     = ($urandom_range(15) == 0);
            req_spi      = ($urandom_range(15) == 0);
            abort_gpio   = ($urandom_range(39) == 0);
            abort_spi    = ($urandom_range(39) == 0);
            eoc_rsa_unit = ($urandom_range(11) == 0);
            tick();
        end
        rst = 0; ena = 1;
        req_gpio = 0; req_spi = 0; abort_gpio = 0; abort_spi = 0; eoc_rsa_unit = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rsa_job_arbiter
`default_nettype wire
